// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe move controller: owns the X/O boards, accepts or refuses moves,
// and turns the external win checker's flags into game_over/winner/fault.
module tictactoe_game_ctrl #(
    parameter bit X_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_nack,
    output logic [8:0] x,
    output logic [8:0] o,
    input  logic       winX,
    input  logic       winO,
    input  logic       full,
    input  logic       error,
    output logic       turn_o,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       fault
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t     state;
    logic [8:0] pos_mask;
    logic       pos_ok;

    // Decode the offered cell; out-of-range positions never match a cell.
    always_comb begin
        pos_mask = 9'd0;
        pos_ok   = 1'b0;
        if (move_pos <= 4'd8) begin
            pos_mask = 9'd1 << move_pos;
            pos_ok   = ((x | o) & pos_mask) == 9'd0;
        end else begin
            pos_mask = 9'd0;
            pos_ok   = 1'b0;
        end
    end

    assign move_ready = (state == PLAY) && !new_game;
    assign game_over  = (state == OVER);

    // Game FSM with registered board, turn, result and handshake pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PLAY;
            x         <= 9'd0;
            o         <= 9'd0;
            turn_o    <= ~X_FIRST;
            winner    <= 2'b00;
            fault     <= 1'b0;
            move_ack  <= 1'b0;
            move_nack <= 1'b0;
        end else begin
            move_ack  <= 1'b0;
            move_nack <= 1'b0;
            if (new_game) begin
                // A simultaneous move is refused; fault is deliberately kept.
                state     <= PLAY;
                x         <= 9'd0;
                o         <= 9'd0;
                turn_o    <= ~X_FIRST;
                winner    <= 2'b00;
                move_nack <= move_valid;
            end else begin
                case (state)
                    PLAY: begin
                        if (move_valid) begin
                            if (pos_ok) begin
                                if (turn_o) begin
                                    o <= o | pos_mask;
                                end else begin
                                    x <= x | pos_mask;
                                end
                                move_ack <= 1'b1;
                                state    <= CHECK;
                            end else begin
                                move_nack <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        move_nack <= move_valid;
                        if (error) begin
                            fault  <= 1'b1;
                            winner <= 2'b00;
                            state  <= OVER;
                        end else if (winX) begin
                            winner <= 2'b01;
                            state  <= OVER;
                        end else if (winO) begin
                            winner <= 2'b10;
                            state  <= OVER;
                        end else if (full) begin
                            winner <= 2'b11;
                            state  <= OVER;
                        end else begin
                            turn_o <= ~turn_o;
                            state  <= PLAY;
                        end
                    end
                    OVER: begin
                        move_nack <= move_valid;
                    end
                    default: begin
                        state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Self-checking bench for tictactoe_game_ctrl with a behavioural win checker
// and an ack/nack scoreboard fed from stimulus tables and short sequences.
module tb_tictactoe_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = 4'd0;
    logic       move_ready, move_ack, move_nack;
    logic [8:0] x, o;
    logic       winX, winO, full, error;
    logic       turn_o, game_over, fault;
    logic [1:0] winner;
    logic       force_err = 1'b0;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic       mv;
        logic [3:0] pos;
        logic       rdy;
        logic       ack;
        logic       nack;
    } vec_t;

    typedef struct {
        logic  ack;
        logic  nack;
        string name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic has_line(input logic [8:0] b);
        return ((b & 9'h007) == 9'h007) || ((b & 9'h038) == 9'h038) ||
               ((b & 9'h1C0) == 9'h1C0) || ((b & 9'h049) == 9'h049) ||
               ((b & 9'h092) == 9'h092) || ((b & 9'h124) == 9'h124) ||
               ((b & 9'h111) == 9'h111) || ((b & 9'h054) == 9'h054);
    endfunction

    assign winX  = has_line(x);
    assign winO  = has_line(o);
    assign full  = ((x | o) == 9'h1FF);
    assign error = ((x & o) != 9'h000) || force_err;

    tictactoe_game_ctrl #(.X_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(move_ready), .move_ack(move_ack),
        .move_nack(move_nack), .x(x), .o(o), .winX(winX), .winO(winO),
        .full(full), .error(error), .turn_o(turn_o), .game_over(game_over),
        .winner(winner), .fault(fault)
    );

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // One clock of stimulus; expected handshake is queued and checked after the edge.
    task automatic cycle(input logic ng, input logic mv, input logic [3:0] p,
                         input logic e_rdy, input logic e_ack, input logic e_nack,
                         input string nm);
        exp_t e;
        @(negedge clk);
        new_game   = ng;
        move_valid = mv;
        move_pos   = p;
        #1;
        chk({nm, " ready"}, {8'd0, move_ready}, {8'd0, e_rdy});
        e.ack  = e_ack;
        e.nack = e_nack;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, " ack"},  {8'd0, move_ack},  {8'd0, e.ack});
        chk({e.name, " nack"}, {8'd0, move_nack}, {8'd0, e.nack});
        chk({e.name, " excl"}, {8'd0, move_ack & move_nack}, 9'd0);
        new_game   = 1'b0;
        move_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " x"}, x, 9'h000);
        chk({nm, " o"}, o, 9'h000);
        chk({nm, " turn"}, {8'd0, turn_o}, 9'd0);
        chk({nm, " winner"}, {7'd0, winner}, 9'd0);
        chk({nm, " over"}, {8'd0, game_over}, 9'd0);
        chk({nm, " fault"}, {8'd0, fault}, 9'd0);
        chk({nm, " ack"}, {8'd0, move_ack}, 9'd0);
        chk({nm, " nack"}, {8'd0, move_nack}, 9'd0);
    endtask

    vec_t win_tbl[13];
    logic [3:0] draw_pos[9];

    initial begin
        win_tbl[0]  = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b0};  // X 0
        win_tbl[1]  = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1};  // offered during CHECK
        win_tbl[2]  = '{1'b1, 4'd9, 1'b1, 1'b0, 1'b1};  // out of range
        win_tbl[3]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b1};  // occupied
        win_tbl[4]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0};  // O 3
        win_tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        win_tbl[6]  = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0};  // X 1
        win_tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        win_tbl[8]  = '{1'b1, 4'd4, 1'b1, 1'b1, 1'b0};  // O 4
        win_tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        win_tbl[10] = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0};  // X 2 wins
        win_tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        win_tbl[12] = '{1'b1, 4'd8, 1'b0, 1'b0, 1'b1};  // refused in OVER
        draw_pos = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

        // Reset overrides simultaneous new_game and move_valid.
        rst = 1'b1; new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0; new_game = 1'b0; move_valid = 1'b0;
        #1;
        chk("reset ready", {8'd0, move_ready}, 9'd1);

        // X wins on the top row, with refused moves interleaved.
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, win_tbl[i].mv, win_tbl[i].pos, win_tbl[i].rdy,
                  win_tbl[i].ack, win_tbl[i].nack, $sformatf("win[%0d]", i));
            if (i == 3) begin
                chk("bad pos board x", x, 9'h001);
                chk("bad pos board o", o, 9'h000);
                chk("bad pos turn", {8'd0, turn_o}, 9'd1);
            end
        end
        chk("win x", x, 9'h007);
        chk("win o", o, 9'h018);
        chk("win winner", {7'd0, winner}, 9'd1);
        chk("win over", {8'd0, game_over}, 9'd1);
        chk("win turn", {8'd0, turn_o}, 9'd0);

        // new_game beats a move offered in OVER.
        cycle(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1, "ng over");
        chk("ng x", x, 9'h000);
        chk("ng o", o, 9'h000);
        chk("ng winner", {7'd0, winner}, 9'd0);
        chk("ng over flag", {8'd0, game_over}, 9'd0);

        // O tries the cell X just took.
        cycle(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0, "x4");
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "x4 chk");
        cycle(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, "o4");
        chk("o4 o", o, 9'h000);
        chk("o4 x", x, 9'h010);
        chk("o4 turn", {8'd0, turn_o}, 9'd1);

        // Draw: every cell filled with no line for either side.
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "ng draw");
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, draw_pos[i], 1'b1, 1'b1, 1'b0, $sformatf("draw mv%0d", i));
            cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, $sformatf("draw chk%0d", i));
        end
        chk("draw x", x, 9'h18D);
        chk("draw o", o, 9'h072);
        chk("draw winner", {7'd0, winner}, 9'd3);
        chk("draw over", {8'd0, game_over}, 9'd1);
        cycle(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, "draw extra");

        // Reset during CHECK drops the pending turn toggle.
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "ng rst");
        cycle(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "rst mv");
        @(negedge clk);
        rst = 1'b1; move_valid = 1'b1; move_pos = 4'd1;
        @(posedge clk);
        #1;
        chk_reset_state("rst mid");
        @(negedge clk);
        rst = 1'b0; move_valid = 1'b0;
        #1;
        chk("rst mid ready", {8'd0, move_ready}, 9'd1);

        // Checker error: fault is sticky across new_game, cleared by rst.
        force_err = 1'b1;
        cycle(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0, "err mv");
        cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "err chk");
        chk("err fault", {8'd0, fault}, 9'd1);
        chk("err winner", {7'd0, winner}, 9'd0);
        chk("err over", {8'd0, game_over}, 9'd1);
        force_err = 1'b0;
        cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "err ng");
        chk("err ng fault", {8'd0, fault}, 9'd1);
        chk("err ng over", {8'd0, game_over}, 9'd0);
        chk("err ng x", x, 9'h000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("err rst fault", {8'd0, fault}, 9'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
